// File: rtl/sha256_const_fetch.sv
// Constant-fetch engine: reads big-endian H/K words from LANES byte-wide EEPROMs
// sharing one address bus and hands them out over a valid/ready port.
module sha256_const_fetch #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned WORDS       = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     index,
  input  logic [6:0]            count,
  output logic                  busy,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*8-1:0]    out_data,
  output logic [ADDR_W-1:0]     out_idx,
  output logic                  done,
  output logic [ADDR_W-1:0]     rom_a,
  output logic                  rom_ce_n,
  output logic                  rom_oe_n,
  output logic                  rom_we_n,
  input  logic [LANES*8-1:0]    rom_d
);

  localparam int unsigned WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0]   WORDS_W = (ADDR_W + 1)'(WORDS);
  localparam logic [WCW-1:0]    WAIT_W  = WCW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t             state, state_nx;
  logic [WCW-1:0]     wcnt;
  logic [ADDR_W-1:0]  cur_idx;
  logic [6:0]         remain;
  logic [ADDR_W:0]    span;
  logic               bad_req;
  logic               acc_last;
  logic               hs;
  logic               last_hs;

  // One extra bit keeps index+count from wrapping past the table end.
  assign span     = {1'b0, index} + (ADDR_W + 1)'(count);
  assign bad_req  = (count == '0) || (span > WORDS_W);
  assign acc_last = (state == ACCESS) && (wcnt == WAIT_W);
  assign hs       = (state == HOLD) && out_valid && out_ready;
  assign last_hs  = hs && (remain == 7'd1);

  assign busy     = (state != IDLE);
  assign rom_we_n = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req && !bad_req) state_nx = ACCESS;
      ACCESS:  if (acc_last)        state_nx = HOLD;
      HOLD:    if (hs)              state_nx = last_hs ? IDLE : ACCESS;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      rom_a     <= '0;
      rom_ce_n  <= 1'b1;
      rom_oe_n  <= 1'b1;
      wcnt      <= '0;
      cur_idx   <= '0;
      remain    <= '0;
    end else begin
      err  <= (state == IDLE) && req && bad_req;
      done <= last_hs;
      case (state)
        IDLE: begin
          if (req && !bad_req) begin
            cur_idx  <= index;
            remain   <= count;
            rom_a    <= index;
            rom_ce_n <= 1'b0;
            rom_oe_n <= 1'b0;
            wcnt     <= '0;
          end
        end
        ACCESS: begin
          if (acc_last) begin
            // Lane 0 already sits in the top byte, so the bus is the word.
            out_data  <= rom_d;
            out_idx   <= cur_idx;
            out_valid <= 1'b1;
            rom_ce_n  <= 1'b1;
            rom_oe_n  <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        HOLD: begin
          if (hs) begin
            out_valid <= 1'b0;
            remain    <= remain - 7'd1;
            if (!last_hs) begin
              cur_idx  <= cur_idx + 1'b1;
              rom_a    <= cur_idx + 1'b1;
              rom_ce_n <= 1'b0;
              rom_oe_n <= 1'b0;
              wcnt     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_const_fetch.sv
// Directed bench for sha256_const_fetch with an EEPROM model and a word scoreboard.
module tb_sha256_const_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] romtab [72] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // DUT 0: default parameters
  logic        req, busy, err, out_valid, out_ready, done, rom_ce_n, rom_oe_n, rom_we_n;
  logic [12:0] index, out_idx, rom_a;
  logic [6:0]  count;
  logic [31:0] out_data, rom_d;

  // DUT 1: zero wait states
  logic        req1, busy1, err1, out_valid1, out_ready1, done1, rom_ce_n1, rom_oe_n1, rom_we_n1;
  logic [12:0] index1, out_idx1, rom_a1;
  logic [6:0]  count1;
  logic [31:0] out_data1, rom_d1;

  // The EEPROM bus only carries data while both enables are low.
  assign rom_d  = (!rom_ce_n  && !rom_oe_n  && rom_a  < 13'd72) ? romtab[rom_a]  : 'x;
  assign rom_d1 = (!rom_ce_n1 && !rom_oe_n1 && rom_a1 < 13'd72) ? romtab[rom_a1] : 'x;

  sha256_const_fetch dut (
    .clk(clk), .rst_n(rst_n), .req(req), .index(index), .count(count),
    .busy(busy), .err(err), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .done(done), .rom_a(rom_a),
    .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n), .rom_d(rom_d)
  );

  sha256_const_fetch #(.WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .index(index1), .count(count1),
    .busy(busy1), .err(err1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .done(done1), .rom_a(rom_a1),
    .rom_ce_n(rom_ce_n1), .rom_oe_n(rom_oe_n1), .rom_we_n(rom_we_n1), .rom_d(rom_d1)
  );

  int tests = 0;
  int fails = 0;
  logic [44:0] sb [$];
  logic [31:0] seen [72];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_a"}, rom_a, 0);
    chk({tag, "_ctl"}, {rom_ce_n, rom_oe_n, rom_we_n}, 3'b111);
  endtask

  // Caller is at a drive point (just after a rising edge).
  task automatic burst(input int idx, input int cnt, input bit rnd,
                       output int last_hs_cyc, output int done_cyc, output int ndone, output int nhs);
    int cyc;
    bit prev_stall;
    logic [31:0] pdata;
    logic [12:0] pidx;
    logic [44:0] e;
    for (int i = 0; i < cnt; i++) sb.push_back({13'(idx + i), romtab[idx + i]});
    req = 1'b1; index = 13'(idx); count = 7'(cnt);
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1 req = 1'b0;
    cyc = 0; ndone = 0; nhs = 0; last_hs_cyc = -1; done_cyc = -1; prev_stall = 0;
    pdata = '0; pidx = '0;
    while (cyc < 3000 && !(sb.size() == 0 && ndone > 0)) begin
      @(negedge clk); cyc++;
      if (prev_stall) begin
        chk("stall_data", out_data, pdata);
        chk("stall_idx", out_idx, pidx);
      end
      if (done) begin ndone++; done_cyc = cyc; chk("done_busy", busy, 0); end
      if (out_valid) chk("hold_ctl", {rom_ce_n, rom_oe_n}, 2'b11);
      else if (busy && sb.size() > 0) begin
        chk("access_ctl", {rom_ce_n, rom_oe_n}, 2'b00);
        chk("access_addr", rom_a, sb[0][44:32]);
      end
      if (out_valid && out_ready) begin
        nhs++; last_hs_cyc = cyc;
        if (sb.size() == 0) chk("extra_word", out_idx, 13'h1fff);
        else begin
          e = sb.pop_front();
          chk("word_idx", out_idx, e[44:32]);
          chk("word_data", out_data, e[31:0]);
          if (out_idx < 13'd72) seen[out_idx] = out_data;
        end
      end
      prev_stall = out_valid && !out_ready;
      pdata = out_data; pidx = out_idx;
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    chk("burst_timeout", cyc < 3000, 1);
    @(negedge clk);
    chk("done_single", done, 0);
    @(posedge clk); #1;
  endtask

  int lh, dc, nd, nh;

  initial begin
    rst_n = 1'b0; req = 1'b0; index = '0; count = '0; out_ready = 1'b0;
    req1 = 1'b0; index1 = '0; count1 = '0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single H word
    burst(0, 1, 0, lh, dc, nd, nh);
    chk("h0_data", seen[0], 32'h6a09e667);
    chk("h0_cycle", lh, 4);
    chk("h0_done_cycle", dc, 5);
    chk("h0_ndone", nd, 1);

    // full K table back to back
    burst(8, 64, 0, lh, dc, nd, nh);
    chk("k_first", seen[8], 32'h428a2f98);
    chk("k_second", seen[9], 32'h71374491);
    chk("k_last", seen[71], 32'hc67178f2);
    chk("k_handshakes", nh, 64);
    chk("k_last_hs_cycle", lh, 256);
    chk("k_ndone", nd, 1);

    // H table with random backpressure
    burst(0, 8, 1, lh, dc, nd, nh);
    out_ready = 1'b1;
    chk("h_first", seen[0], 32'h6a09e667);
    chk("h_last", seen[7], 32'h5be0cd19);
    chk("h_handshakes", nh, 8);

    // rejected requests: past the end, then zero length
    for (int t = 0; t < 2; t++) begin
      req = 1'b1; index = 13'd70; count = (t == 0) ? 7'd3 : 7'd0;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_ce", rom_ce_n, 1);
      chk("rej_done", done, 0);
      @(negedge clk);
      chk("rej_err_pulse", err, 0);
      chk("rej_idle", busy, 0);
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of the 3rd K word
    req = 1'b1; index = 13'd8; count = 7'd8; out_ready = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_addr", rom_a, 13'd10);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    burst(4, 1, 0, lh, dc, nd, nh);
    chk("after_rst_data", seen[4], 32'h510e527f);

    // zero-wait build; requests while busy must be ignored
    req1 = 1'b1; index1 = 13'd1; count1 = 7'd1; out_ready1 = 1'b0;
    @(posedge clk); #1 index1 = 13'd5;
    @(negedge clk);
    chk("w0_c1_access", {busy1, out_valid1, rom_ce_n1}, 3'b100);
    @(negedge clk);
    chk("w0_c2_valid", out_valid1, 1);
    chk("w0_c2_data", out_data1, 32'hbb67ae85);
    chk("w0_c2_idx", out_idx1, 13'd1);
    @(negedge clk);
    chk("w0_stall_data", out_data1, 32'hbb67ae85);
    req1 = 1'b0; out_ready1 = 1'b1;
    @(negedge clk);
    chk("w0_done", {done1, busy1, out_valid1}, 3'b100);
    repeat (3) begin
      @(negedge clk);
      chk("w0_ignored", {busy1, out_valid1, err1}, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha256_const_fetch.md
# sha256_const_fetch

Parametrised constant-fetch engine for the SHA-256 datapath. It drives the shared address and control pins of `LANES` parallel 8-bit EEPROM chips, which together hold the H and K constant tables as byte lanes. It waits a programmable number of access cycles, then assembles one big-endian word per access. Single words or sequential bursts are delivered to the round logic over a valid/ready handshake with full backpressure.

## Interface
Parameters:
- `LANES`, 4: number of byte-lane EEPROMs; word width is `LANES*8`.
- `ADDR_W`, 13: EEPROM address width.
- `WAIT_CYCLES`, 2: extra cycles the address is held before data is sampled (0 allowed).
- `WORDS`, 72: valid word indices are 0..WORDS-1 (0-7 H, 8-71 K).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: start request, sampled only in IDLE.
- `index` in ADDR_W: first word index, sampled with `req`.
- `count` in 7: number of words in the burst, sampled with `req`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse when a request is rejected.
- `out_valid` out 1: `out_data` holds a word.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out LANES*8: assembled word; lane 0 is the MSB byte.
- `out_idx` out ADDR_W: index of the word in `out_data`.
- `done` out 1: one-cycle pulse on handshake of the last burst word.
- `rom_a` out ADDR_W: shared EEPROM address.
- `rom_ce_n`, `rom_oe_n` out 1: active-low chip enable and output enable.
- `rom_we_n` out 1: tied high at all times, including reset.
- `rom_d` in LANES*8: lane k drives bits [LANES*8-1-8k -: 8].

## Operation
- FSM states: IDLE, ACCESS, HOLD.
- IDLE:
  - On `req`=1, the request is checked.
  - If `count`==0 or `index`+`count` > `WORDS` (computed at ADDR_W+1 bits, no wrap), the request is rejected: `err` pulses the next cycle and the FSM stays in IDLE.
  - Otherwise `cur_idx`=`index` and `remain`=`count` are latched and the FSM goes to ACCESS.
- ACCESS:
  - Lasts exactly WAIT_CYCLES+1 cycles, counted by the wait counter.
  - `rom_a`=`cur_idx`, `rom_ce_n`=0, `rom_oe_n`=0 throughout.
  - On the clock edge that ends the last ACCESS cycle: `out_data`<=`rom_d`, `out_idx`<=`cur_idx`, `out_valid`<=1, and the FSM goes to HOLD.
- HOLD:
  - `rom_ce_n`=`rom_oe_n`=1.
  - `out_data` and `out_idx` stay stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid`&&`out_ready`: `out_valid`<=0 and `remain` decrements.
  - If `remain` was 1: `done` pulses and the FSM goes to IDLE.
  - Otherwise `cur_idx`+1 is taken and the FSM goes to ACCESS.
- Assembled word: `out_data` = {lane0, lane1, ..., lane LANES-1}.
- `req` is ignored while `busy`=1. No abort exists; only reset stops a burst.
- Reset, including mid-burst, is immediate and asynchronous. It forces IDLE, `busy`=0, `err`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `done`=0, `rom_a`=0, `rom_ce_n`=`rom_oe_n`=`rom_we_n`=1, and clears the wait counter, `cur_idx` and `remain`.

## Timing
- Edge 0 samples `req`. ACCESS occupies cycles 1..WAIT_CYCLES+1. `out_valid` is high from cycle WAIT_CYCLES+2.
- First-word latency is WAIT_CYCLES+2 cycles; 4 cycles with defaults.
- With `out_ready` held at 1, words are delivered one per WAIT_CYCLES+2 cycles; 4 cycles with defaults.
- `done` is asserted in the cycle after the final handshake edge, with `busy`=0 in the same cycle. A new `req` is accepted in that same cycle.
- `rom_a` changes only on entry to ACCESS, and the address is stable for the whole ACCESS window.
- `err` and `done` are never asserted in the same cycle.
- All outputs are registered; there is no combinational path from `out_ready` to any output.

## Test plan
- Reset, then `req` with `index`=0, `count`=1 and `out_ready`=1 → `out_data`=0x6a09e667 and `out_idx`=0 at cycle 4, `done` at cycle 5, `rom_ce_n` high again in HOLD.
- Burst `index`=8, `count`=64 with `out_ready`=1 → first word 0x428a2f98, word at index 9 is 0x71374491, last word (index 71) 0xc67178f2, 64 handshakes, 256 cycles total, a single `done` pulse.
- Burst `index`=0, `count`=8 with `out_ready` toggling randomly → the sequence 0x6a09e667 … 0x5be0cd19 arrives in order, with data and index stable while stalled.
- `index`=70, `count`=3 → `err` pulses once, `busy` stays 0, `rom_ce_n` stays 1. Repeat with `count`=0 → same result.
- Assert `rst_n`=0 during the 3rd word of a K burst → all outputs return to their reset values asynchronously. A new `index`=4 request then returns 0x510e527f.
- `WAIT_CYCLES`=0 build, `index`=1 → 0x bb67ae85 arrives at cycle 2; `req` pulses while `busy`=1 are ignored.
